// File: rtl/psram_arbiter.sv
// Two-port PSRAM arbiter: serialises DCJ11 (port C) and Apple II (port A)
// requests onto the single ram command interface, CPU-priority with A2 anti-starvation.
module psram_arbiter #(
    parameter int MAX_CPU_RUN = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [21:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,

    input  logic        a2_req,
    input  logic        a2_we,
    input  logic        a2_byte,
    input  logic [21:0] a2_addr,
    input  logic [15:0] a2_wdata,
    output logic        a2_ack,
    output logic [15:0] a2_rdata,

    output logic        ram_read,
    output logic        ram_write,
    output logic        ram_byte,
    output logic [21:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        ram_done,

    output logic        err,
    output logic        grant_a2
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_CPU_RUN);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  run_q, run_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic [21:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        grant_a2_q, grant_a2_d;
    logic        ram_read_q, ram_read_d;
    logic        ram_write_q, ram_write_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        a2_ack_q, a2_ack_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] a2_rdata_q, a2_rdata_d;
    logic        err_q, err_d;
    logic        pick_a2;
    logic        sel_we;
    logic [15:0] fill;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        tcnt_d      = tcnt_q;
        we_d        = we_q;
        byte_d      = byte_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        grant_a2_d  = grant_a2_q;
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        cpu_ack_d   = 1'b0;
        a2_ack_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        a2_rdata_d  = a2_rdata_q;
        err_d       = err_q;
        pick_a2     = a2_req && (!cpu_req || (run_q == RUN_MAX));
        sel_we      = pick_a2 ? a2_we : cpu_we;
        fill        = ram_done ? ram_rdata : 16'hFFFF;

        unique case (state_q)
            S_INIT: begin
                if (init) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cpu_req || a2_req) begin
                    we_d        = sel_we;
                    byte_d      = pick_a2 ? a2_byte  : cpu_byte;
                    addr_d      = pick_a2 ? a2_addr  : cpu_addr;
                    wdata_d     = pick_a2 ? a2_wdata : cpu_wdata;
                    grant_a2_d  = pick_a2;
                    ram_read_d  = !sel_we;
                    ram_write_d = sel_we;
                    state_d     = S_ISSUE;
                    // Run length only grows while A2 is actually being held off
                    if (pick_a2 || !a2_req) begin
                        run_d = 4'd0;
                    end else if (run_q != RUN_MAX) begin
                        run_d = run_q + 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                tcnt_d  = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ram_done || (tcnt_q == TO_LAST)) begin
                    state_d = S_ACK;
                    if (!ram_done) begin
                        err_d = 1'b1;
                    end
                    if (grant_a2_q) begin
                        a2_ack_d = 1'b1;
                        if (!we_q) begin
                            a2_rdata_d = fill;
                        end
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) begin
                            cpu_rdata_d = fill;
                        end
                    end
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            run_q       <= 4'd0;
            tcnt_q      <= 8'd0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            addr_q      <= 22'd0;
            wdata_q     <= 16'h0000;
            grant_a2_q  <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            a2_ack_q    <= 1'b0;
            cpu_rdata_q <= 16'h0000;
            a2_rdata_q  <= 16'h0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            tcnt_q      <= tcnt_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            grant_a2_q  <= grant_a2_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            cpu_ack_q   <= cpu_ack_d;
            a2_ack_q    <= a2_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            a2_rdata_q  <= a2_rdata_d;
            err_q       <= err_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign a2_ack    = a2_ack_q;
    assign a2_rdata  = a2_rdata_q;
    assign ram_read  = ram_read_q;
    assign ram_write = ram_write_q;
    assign ram_byte  = byte_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign err       = err_q;
    assign grant_a2  = grant_a2_q;

endmodule
